// File: rtl/vram_write_arbiter_pkg.sv
// Shared VRAM write-port constants and the packed write-record type used by the
// framebuffer write arbiter and its neighbours.
package fractaski_vram_pkg;

    localparam int VRAM_ADDR_W  = 18;
    localparam int VRAM_DATA_W  = 8;
    localparam int VRAM_NUM_REQ = 64;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0] data;
    } vram_wr_t;

endpackage

// File: rtl/vram_write_arbiter_if.sv
// Bundle of tile request ports and the VRAM write port seen by the arbiter.
// The arbiter connects through the slave modport; the tile/VRAM side uses master.
interface vram_write_arbiter_if
    import fractaski_vram_pkg::*;
#(
    parameter int NUM_REQ = VRAM_NUM_REQ,
    parameter int ADDR_W  = VRAM_ADDR_W,
    parameter int DATA_W  = VRAM_DATA_W
) ();

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                        hold;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        vram_valid;
    logic                        vram_ready;
    logic [ADDR_W-1:0]           vram_addr;
    logic [DATA_W-1:0]           vram_wdata;
    logic [IDX_W-1:0]            vram_src;
    logic                        idle;

    modport master (
        output hold, req_valid, req_addr, req_data, vram_ready,
        input  req_ready, vram_valid, vram_addr, vram_wdata, vram_src, idle
    );

    modport slave (
        input  hold, req_valid, req_addr, req_data, vram_ready,
        output req_ready, vram_valid, vram_addr, vram_wdata, vram_src, idle
    );

endinterface

// File: rtl/vram_write_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: lowest set request at or above ptr, else the
// lowest set request overall (wrap). Emits one-hot grant, its index and an any flag.
module rr_priority_picker #(
    parameter int NUM_REQ = 64,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [NUM_REQ-1:0] masked_s;
    logic [NUM_REQ-1:0] sel_s;
    logic [IDX_W-1:0]   idx_s;

    // Masked fixed-priority first, falling back to the unmasked vector when nothing sits at/above ptr
    always_comb begin
        masked_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            masked_s[i] = req[i] & (i >= int'(ptr));
        end
        sel_s = (|masked_s) ? masked_s : req;
        idx_s = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx_s = sel_s[i] ? IDX_W'(i) : idx_s;
        end
    end

    // One-hot grant derived from the chosen index
    always_comb begin
        any = |req;
        idx = idx_s;
        if (any) begin
            grant = NUM_REQ'(1) << idx_s;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/vram_write_arbiter.sv
// Round-robin arbiter sharing the single VRAM write port among all tiles: one
// winner per cycle is captured into a registered output slot driving VRAM.
module vram_write_arbiter
    import fractaski_vram_pkg::*;
#(
    parameter int NUM_REQ = VRAM_NUM_REQ,
    parameter int ADDR_W  = VRAM_ADDR_W,
    parameter int DATA_W  = VRAM_DATA_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    vram_write_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } slot_t;

    slot_t              slot_r;
    logic               valid_r;
    logic [IDX_W-1:0]   src_r;
    logic [IDX_W-1:0]   ptr_r;

    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic               any_s;
    logic               slot_free_s;
    logic               grant_en_s;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req   (bus.req_valid),
        .ptr   (ptr_r),
        .grant (grant_s),
        .idx   (win_idx_s),
        .any   (any_s)
    );

    // Grant only when the slot empties this cycle; reset_n gating keeps req_ready low during reset
    always_comb begin
        slot_free_s = ~valid_r | bus.vram_ready;
        grant_en_s  = slot_free_s & ~bus.hold & any_s & reset_n;
        if (grant_en_s) begin
            bus.req_ready = grant_s;
        end else begin
            bus.req_ready = '0;
        end
    end

    // Output slot and round-robin pointer; the pointer moves only on a transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_r  <= '0;
            valid_r <= 1'b0;
            src_r   <= '0;
            ptr_r   <= '0;
        end else if (grant_en_s) begin
            valid_r     <= 1'b1;
            slot_r.addr <= bus.req_addr[win_idx_s*ADDR_W +: ADDR_W];
            slot_r.data <= bus.req_data[win_idx_s*DATA_W +: DATA_W];
            src_r       <= win_idx_s;
            ptr_r       <= (win_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_s + IDX_W'(1);
        end else if (bus.vram_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Registered VRAM port plus the combinational idle summary
    always_comb begin
        bus.vram_valid = valid_r;
        bus.vram_addr  = slot_r.addr;
        bus.vram_wdata = slot_r.data;
        bus.vram_src   = src_r;
        bus.idle       = ~valid_r & ~(|bus.req_valid);
    end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Scoreboard bench for vram_write_arbiter with 8 requesters: expected writes are
// queued at grant time and compared as the VRAM side consumes them.
module tb_vram_write_arbiter;
    import fractaski_vram_pkg::*;

    localparam int NR = 8;
    localparam int AW = VRAM_ADDR_W;
    localparam int DW = VRAM_DATA_W;

    typedef struct packed {
        logic [2:0] src;
        vram_wr_t   wr;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [AW-1:0] ta [NR];
    logic [DW-1:0] td [NR];

    vram_write_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) vif ();

    vram_write_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge, then return at the sampling edge
    task automatic step(input logic [NR-1:0] v, input logic rdy, input logic h);
        @(posedge clk);
        #1;
        vif.req_valid  = v;
        vif.vram_ready = rdy;
        vif.hold       = h;
        @(negedge clk);
    endtask

    task automatic expect_grant(input int t);
        exp_t e;
        chk("req_ready", 32'(vif.req_ready), 32'(1) << t);
        e.src     = 3'(t);
        e.wr.addr = ta[t];
        e.wr.data = td[t];
        sb_q.push_back(e);
    endtask

    // Consumer side: every accepted VRAM write must match the oldest queued expectation
    always @(negedge clk) begin
        if (reset_n && vif.vram_valid && vif.vram_ready) begin
            chk("sb_pending", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("wr_src",  32'(vif.vram_src),   32'(mon_e.src));
                chk("wr_addr", 32'(vif.vram_addr),  32'(mon_e.wr.addr));
                chk("wr_data", 32'(vif.vram_wdata), 32'(mon_e.wr.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        vif.hold       = 1'b0;
        vif.req_valid  = '0;
        vif.vram_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            ta[i] = 18'h0_0ABC + 18'(i) * 18'h0_1000;
            td[i] = 8'h10 + 8'(i);
        end
        ta[5] = 18'h1_2345;
        td[5] = 8'hA7;
        for (int i = 0; i < NR; i++) begin
            vif.req_addr[i*AW +: AW] = ta[i];
            vif.req_data[i*DW +: DW] = td[i];
        end

        // Power-on reset
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("por_vvalid", 32'(vif.vram_valid), 32'd0);
        chk("por_addr",   32'(vif.vram_addr),  32'd0);
        chk("por_src",    32'(vif.vram_src),   32'd0);
        chk("por_idle",   32'(vif.idle),       32'd1);
        step(8'h00, 1'b1, 1'b0);
        chk("por_stay",   32'(vif.vram_valid), 32'd0);

        // Single tile 5
        step(8'h20, 1'b1, 1'b0);
        expect_grant(5);
        step(8'h00, 1'b1, 1'b0);
        chk("t5_vvalid", 32'(vif.vram_valid), 32'd1);
        chk("t5_addr",   32'(vif.vram_addr),  32'h12345);
        chk("t5_wdata",  32'(vif.vram_wdata), 32'hA7);
        chk("t5_src",    32'(vif.vram_src),   32'd5);

        // Wrap past the top index: ptr=6, tiles 7 and 0 valid
        step(8'h81, 1'b1, 1'b0);
        expect_grant(7);
        step(8'h81, 1'b1, 1'b0);
        expect_grant(0);
        step(8'h00, 1'b1, 1'b0);

        // Reset while the slot holds a stalled write
        step(8'h04, 1'b0, 1'b0);
        expect_grant(2);
        step(8'h00, 1'b0, 1'b0);
        chk("pre_rst_vvalid", 32'(vif.vram_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_vvalid", 32'(vif.vram_valid), 32'd0);
        chk("rst_addr",   32'(vif.vram_addr),  32'd0);
        chk("rst_wdata",  32'(vif.vram_wdata), 32'd0);
        chk("rst_src",    32'(vif.vram_src),   32'd0);
        chk("rst_idle",   32'(vif.idle),       32'd1);
        vif.req_valid = 8'hFF;
        #1;
        chk("rst_ready",  32'(vif.req_ready),  32'd0);
        vif.req_valid = 8'h00;
        sb_q.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
        step(8'h00, 1'b1, 1'b0);
        chk("rel_vvalid0", 32'(vif.vram_valid), 32'd0);
        step(8'h00, 1'b1, 1'b0);
        chk("rel_vvalid1", 32'(vif.vram_valid), 32'd0);

        // Round-robin over tiles 0..3, back-to-back
        for (int k = 0; k < 8; k++) begin
            step(8'h0F, 1'b1, 1'b0);
            expect_grant(k % 4);
            if (k > 0) chk("rr_no_bubble", 32'(vif.vram_valid), 32'd1);
        end
        step(8'h00, 1'b1, 1'b0);
        chk("rr_tail", 32'(vif.vram_valid), 32'd1);

        // Skip non-requesting tiles: reach ptr=3, then tiles 0 and 2
        step(8'h04, 1'b1, 1'b0);
        expect_grant(2);
        step(8'h05, 1'b1, 1'b0);
        expect_grant(0);
        step(8'h05, 1'b1, 1'b0);
        expect_grant(2);
        step(8'h05, 1'b1, 1'b0);
        expect_grant(0);
        step(8'h00, 1'b1, 1'b0);

        // Backpressure
        step(8'h0F, 1'b1, 1'b0);
        expect_grant(1);
        for (int k = 0; k < 3; k++) begin
            step(8'h0F, 1'b0, 1'b0);
            chk("bp_ready",  32'(vif.req_ready),  32'd0);
            chk("bp_vvalid", 32'(vif.vram_valid), 32'd1);
            chk("bp_src",    32'(vif.vram_src),   32'd1);
            chk("bp_addr",   32'(vif.vram_addr),  32'(ta[1]));
        end
        step(8'h0F, 1'b1, 1'b0);
        expect_grant(2);
        step(8'h0F, 1'b1, 1'b0);
        expect_grant(3);
        step(8'h0F, 1'b1, 1'b0);
        expect_grant(0);
        step(8'h00, 1'b1, 1'b0);

        // Hold blocks grants while the slot drains
        step(8'h0F, 1'b0, 1'b0);
        expect_grant(1);
        step(8'h0F, 1'b0, 1'b1);
        chk("hold_ready0", 32'(vif.req_ready),  32'd0);
        chk("hold_vvalid", 32'(vif.vram_valid), 32'd1);
        chk("hold_idle0",  32'(vif.idle),       32'd0);
        step(8'h0F, 1'b1, 1'b1);
        chk("hold_ready1", 32'(vif.req_ready),  32'd0);
        step(8'h0F, 1'b1, 1'b1);
        chk("hold_drained", 32'(vif.vram_valid), 32'd0);
        chk("hold_ready2",  32'(vif.req_ready),  32'd0);
        chk("hold_idle1",   32'(vif.idle),       32'd0);
        step(8'h0F, 1'b1, 1'b0);
        expect_grant(2);
        step(8'h00, 1'b1, 1'b0);
        chk("end_idle0", 32'(vif.idle), 32'd0);
        step(8'h00, 1'b1, 1'b0);
        chk("end_idle1", 32'(vif.idle), 32'd1);
        chk("sb_empty",  32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
